// File: rtl/hex2ascii_tx.sv
// hex2ascii_tx: streams a binary word out as printable ASCII hex, most significant nibble first.
// Define HEX2ASCII_CRLF_EN to terminate every word with CR (0x0D) and LF (0x0A).
module hex2ascii_tx #(
  parameter int NIBBLES   = 8,
  parameter bit LOWERCASE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*NIBBLES-1:0] word_in,
  input  logic                 word_valid,
  output logic                 word_ready,
  output logic [7:0]           ascii_data,
  output logic                 ascii_valid,
  input  logic                 ascii_ready,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

`ifdef HEX2ASCII_CRLF_EN
  typedef enum logic [1:0] {IDLE, DIGIT, CR, LF} state_t;
`else
  typedef enum logic {IDLE, DIGIT} state_t;
`endif

  state_t          state_q;
  logic [W-1:0]    shift_q;
  logic [W-1:0]    shift_d;
  logic [CW-1:0]   cnt_q;
  logic            word_ready_q;
  logic            ascii_valid_q;
  logic [7:0]      ascii_data_q;
  logic            word_acc;
  logic            char_acc;

  function automatic logic [7:0] hexChar(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else if (LOWERCASE) return 8'h57 + {4'h0, nib};
    else return 8'h37 + {4'h0, nib};
  endfunction

  assign shift_d  = shift_q << 4;
  assign word_acc = word_valid & word_ready_q;
  assign char_acc = ascii_valid_q & ascii_ready;

  // The next character is computed from the already-shifted word so there is no bubble between digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      word_ready_q  <= 1'b0;
      ascii_valid_q <= 1'b0;
      ascii_data_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          word_ready_q <= 1'b1;
          if (word_acc) begin
            shift_q       <= word_in;
            cnt_q         <= '0;
            ascii_data_q  <= hexChar(word_in[W-1 -: 4]);
            ascii_valid_q <= 1'b1;
            word_ready_q  <= 1'b0;
            state_q       <= DIGIT;
          end
        end
        DIGIT: begin
          if (char_acc) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
`ifdef HEX2ASCII_CRLF_EN
              ascii_data_q  <= 8'h0D;
              state_q       <= CR;
`else
              ascii_valid_q <= 1'b0;
              word_ready_q  <= 1'b1;
              state_q       <= IDLE;
`endif
            end else begin
              ascii_data_q <= hexChar(shift_d[W-1 -: 4]);
            end
          end
        end
`ifdef HEX2ASCII_CRLF_EN
        CR: begin
          if (char_acc) begin
            ascii_data_q <= 8'h0A;
            state_q      <= LF;
          end
        end
        LF: begin
          if (char_acc) begin
            ascii_valid_q <= 1'b0;
            word_ready_q  <= 1'b1;
            state_q       <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign word_ready  = word_ready_q;
  assign ascii_valid = ascii_valid_q;
  assign ascii_data  = ascii_data_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_hex2ascii_tx.sv
// Self-checking bench for hex2ascii_tx: a default 8-digit uppercase instance and a 2-digit lowercase instance,
// each compared cycle by cycle against a character-list reference model.
module tb_hex2ascii_tx;

  typedef logic [7:0] charQ_t[$];

`ifdef HEX2ASCII_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wordIn;
  logic        wordValid;
  logic        wordReady;
  logic [7:0]  asciiData;
  logic        asciiValid;
  logic        asciiReady;
  logic        busy;

  logic [7:0]  wordIn2;
  logic        wordValid2;
  logic        wordReady2;
  logic [7:0]  asciiData2;
  logic        asciiValid2;
  logic        asciiReady2;
  logic        busy2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hex2ascii_tx #(.NIBBLES(8), .LOWERCASE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .word_in(wordIn), .word_valid(wordValid), .word_ready(wordReady),
    .ascii_data(asciiData), .ascii_valid(asciiValid), .ascii_ready(asciiReady), .busy(busy)
  );

  hex2ascii_tx #(.NIBBLES(2), .LOWERCASE(1'b1)) dutLower (
    .clk(clk), .rst_n(rst_n), .word_in(wordIn2), .word_valid(wordValid2), .word_ready(wordReady2),
    .ascii_data(asciiData2), .ascii_valid(asciiValid2), .ascii_ready(asciiReady2), .busy(busy2)
  );

  // Every comparison funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] refHex(input int v, input bit lc);
    if (v < 10) return 8'(48 + v);
    return lc ? 8'(97 + v - 10) : 8'(65 + v - 10);
  endfunction

  // The character stream a word should produce, read straight off the hex digits.
  function automatic charQ_t refChars(input logic [63:0] w, input int n, input bit lc, input bit crlf);
    charQ_t q;
    for (int i = n - 1; i >= 0; i--)
      q.push_back(refHex(int'((w >> (4 * i)) & 64'hF), lc));
    if (crlf) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
    return q;
  endfunction

  // Sends one word from an idle negedge and checks every cycle until the block is idle again.
  // stallAt/stallLen hold off one chosen character; abortAfter pulls reset after that many characters.
  task automatic applyStimulus(input logic [31:0] w, input bit randReady, input int stallAt,
                               input int stallLen, input bit holdNext, input logic [31:0] nextW,
                               input int abortAfter);
    charQ_t exp;
    int idx;
    int stalled;
    int waitRun;
    exp     = refChars({32'h0, w}, 8, 1'b0, CRLF);
    idx     = 0;
    stalled = 0;
    waitRun = 0;
    checkOutput("idle_wready", 32'(wordReady), 32'd1);
    checkOutput("idle_valid", 32'(asciiValid), 32'd0);
    wordIn    = w;
    wordValid = 1'b1;
    @(negedge clk);
    while (idx < exp.size()) begin
      if (idx == abortAfter) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(asciiValid), 32'd0);
        checkOutput("rst_wready", 32'(wordReady), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_data", 32'(asciiData), 32'h00);
        wordValid  = 1'b0;
        asciiReady = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rel_wready", 32'(wordReady), 32'd1);
        repeat (4) begin
          checkOutput("rel_valid", 32'(asciiValid), 32'd0);
          checkOutput("rel_busy", 32'(busy), 32'd0);
          @(negedge clk);
        end
        return;
      end
      checkOutput("char_valid", 32'(asciiValid), 32'd1);
      checkOutput("char_data", 32'(asciiData), 32'(exp[idx]));
      checkOutput("char_busy", 32'(busy), 32'd1);
      checkOutput("char_wready", 32'(wordReady), 32'd0);
      if (holdNext) begin
        wordValid = 1'b1;
        wordIn    = nextW;
      end else begin
        wordValid = 1'($urandom);
        wordIn    = $urandom;
      end
      if (idx == stallAt && stalled < stallLen) begin
        asciiReady = 1'b0;
        stalled++;
      end else if (randReady && waitRun < 3 && $urandom_range(0, 2) == 0) begin
        asciiReady = 1'b0;
        waitRun++;
      end else begin
        asciiReady = 1'b1;
        waitRun    = 0;
        idx++;
      end
      @(negedge clk);
    end
    wordValid = holdNext;
    checkOutput("end_valid", 32'(asciiValid), 32'd0);
    checkOutput("end_busy", 32'(busy), 32'd0);
    checkOutput("end_wready", 32'(wordReady), 32'd1);
  endtask

  task automatic applyStimulus2(input logic [7:0] w, input bit holdNext, input logic [7:0] nextW);
    charQ_t exp;
    exp = refChars({56'h0, w}, 2, 1'b1, CRLF);
    checkOutput("lc_idle_wready", 32'(wordReady2), 32'd1);
    wordIn2    = w;
    wordValid2 = 1'b1;
    @(negedge clk);
    foreach (exp[i]) begin
      checkOutput("lc_valid", 32'(asciiValid2), 32'd1);
      checkOutput("lc_data", 32'(asciiData2), 32'(exp[i]));
      wordValid2 = holdNext;
      wordIn2    = holdNext ? nextW : 8'($urandom);
      @(negedge clk);
    end
    wordValid2 = holdNext;
    checkOutput("lc_end_valid", 32'(asciiValid2), 32'd0);
    checkOutput("lc_end_wready", 32'(wordReady2), 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    wordIn      = '0;
    wordValid   = 1'b0;
    asciiReady  = 1'b1;
    wordIn2     = '0;
    wordValid2  = 1'b0;
    asciiReady2 = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_wready", 32'(wordReady), 32'd0);
    checkOutput("reset_valid", 32'(asciiValid), 32'd0);
    checkOutput("reset_data", 32'(asciiData), 32'h00);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_lc_wready", 32'(wordReady2), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("first_wready", 32'(wordReady), 32'd1);

    applyStimulus(32'h1234ABCD, 1'b0, -1, 0, 1'b0, 32'h0, -1);
    applyStimulus(32'h1234ABCD, 1'b0, 2, 5, 1'b0, 32'h0, -1);
    applyStimulus(32'h00000000, 1'b0, -1, 0, 1'b1, 32'h55555555, -1);
    applyStimulus(32'h55555555, 1'b0, -1, 0, 1'b0, 32'h0, -1);
    applyStimulus(32'h1234ABCD, 1'b0, -1, 0, 1'b0, 32'h0, 3);
    applyStimulus(32'hFFFFFFFF, 1'b0, 7, 2, 1'b0, 32'h0, -1);
    applyStimulus(32'h9A0F5E61, 1'b0, 0, 3, 1'b0, 32'h0, -1);
    for (int n = 0; n < 20; n++) begin
      logic [31:0] rw;
      logic [31:0] nw;
      bit          hold;
      rw   = $urandom;
      nw   = $urandom;
      hold = 1'($urandom);
      applyStimulus(rw, 1'b1, -1, 0, hold, nw, -1);
      if (hold) applyStimulus(nw, 1'b1, -1, 0, 1'b0, 32'h0, -1);
    end

    applyStimulus2(8'h0F, 1'b1, 8'hA0);
    applyStimulus2(8'hA0, 1'b0, 8'h00);
    applyStimulus2(8'hDE, 1'b0, 8'h00);
    applyStimulus2(8'hAD, 1'b0, 8'h00);
    applyStimulus2(8'hBE, 1'b0, 8'h00);
    applyStimulus2(8'hEF, 1'b0, 8'h00);
    for (int n = 0; n < 8; n++) applyStimulus2(8'($urandom), 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
